// File: rtl/maltsev_pkg.sv
// Shared definitions for the ST/RD operation-call blocks: state encoding,
// default widths and the watchdog timer sizing rule.
package maltsev_pkg;

    localparam int unsigned BW_DEF  = 16;
    localparam int unsigned TMO_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    // Timer must hold TMO-1 with headroom.
    function automatic int unsigned timer_w(input int unsigned tmo);
        return $clog2(tmo) + 1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a handshake strobe. The history register is not
// reset so a strobe held high across reset release is not seen as an edge.
module rise_detect (
    input  logic clk,
    input  logic sig,
    output logic rise_c
);

    logic sig_q;

    always_ff @(posedge clk) begin
        sig_q <= sig;
    end

    assign rise_c = sig & ~sig_q;

endmodule

// File: rtl/operation_call_16_2.sv
// Initiator for a two-operand ST/RD operation call with a watchdog that
// releases the upstream sequencer if the callee never completes.
module operation_call_16_2
    import maltsev_pkg::*;
#(
    parameter int unsigned BW  = BW_DEF,
    parameter int unsigned TMO = TMO_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ST,
    output logic          RD,
    output logic [BW-1:0] RES,
    output logic          ERR,
    input  logic [BW-1:0] IN0,
    input  logic [BW-1:0] IN1,
    output logic          OST,
    input  logic          ORD,
    input  logic [BW-1:0] ORES,
    output logic [BW-1:0] OIN0,
    output logic [BW-1:0] OIN1
);

    localparam int unsigned TW = timer_w(TMO);

    state_t          state, state_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic            rd_nxt, err_nxt, ost_nxt;
    logic [BW-1:0]   res_nxt, oin0_nxt, oin1_nxt;
    logic            st_rise_c;
    logic            expired_c;

    rise_detect u_rise (
        .clk    (CLK),
        .sig    (ST),
        .rise_c (st_rise_c)
    );

    assign expired_c = (timer == TW'(TMO - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            timer <= '0;
            RD    <= 1'b1;
            RES   <= '0;
            ERR   <= 1'b0;
            OST   <= 1'b0;
            OIN0  <= '0;
            OIN1  <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            RD    <= rd_nxt;
            RES   <= res_nxt;
            ERR   <= err_nxt;
            OST   <= ost_nxt;
            OIN0  <= oin0_nxt;
            OIN1  <= oin1_nxt;
        end
    end

    // Normal exits are tested before the watchdog so a same-cycle completion wins.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        rd_nxt    = RD;
        res_nxt   = RES;
        err_nxt   = ERR;
        ost_nxt   = OST;
        oin0_nxt  = OIN0;
        oin1_nxt  = OIN1;

        unique case (state)
            S_IDLE: begin
                if (st_rise_c) begin
                    oin0_nxt  = IN0;
                    oin1_nxt  = IN1;
                    ost_nxt   = 1'b1;
                    rd_nxt    = 1'b0;
                    err_nxt   = 1'b0;
                    timer_nxt = '0;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                timer_nxt = timer + TW'(1);
                if (!ORD) begin
                    ost_nxt   = 1'b0;
                    state_nxt = S_WAIT;
                end else if (expired_c) begin
                    res_nxt   = '0;
                    err_nxt   = 1'b1;
                    ost_nxt   = 1'b0;
                    rd_nxt    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                timer_nxt = timer + TW'(1);
                if (ORD) begin
                    res_nxt   = ORES;
                    rd_nxt    = 1'b1;
                    state_nxt = S_IDLE;
                end else if (expired_c) begin
                    res_nxt   = '0;
                    err_nxt   = 1'b1;
                    ost_nxt   = 1'b0;
                    rd_nxt    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_operation_call_16_2.sv
// Bench for operation_call_16_2 with a behavioural callee and a latency/result
// reference model derived from the handshake rules.
module tb_operation_call_16_2;

    localparam int unsigned BW  = 16;
    localparam int unsigned TMO = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          ST  = 1'b0;
    logic          RD, ERR, OST;
    logic [BW-1:0] RES, OIN0, OIN1;
    logic [BW-1:0] IN0 = '0;
    logic [BW-1:0] IN1 = '0;
    logic          ORD = 1'b1;
    logic [BW-1:0] ORES = '0;

    int tests = 0;
    int fails = 0;

    operation_call_16_2 #(.BW(BW), .TMO(TMO)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .ST   (ST),
        .RD   (RD),
        .RES  (RES),
        .ERR  (ERR),
        .IN0  (IN0),
        .IN1  (IN1),
        .OST  (OST),
        .ORD  (ORD),
        .ORES (ORES),
        .OIN0 (OIN0),
        .OIN1 (OIN1)
    );

    always #5 CLK = ~CLK;

    // Callee: edge-triggered on OST, ORD low for callee_busy edges.
    logic          callee_stuck = 1'b0;
    logic          callee_xor   = 1'b1;
    logic [BW-1:0] callee_val   = '0;
    int            callee_busy  = 2;
    int            cnt          = 0;
    logic          ost_q        = 1'b0;
    logic          rd_q         = 1'b1;
    int            ost_rises    = 0;
    int            rd_rises     = 0;

    always @(posedge CLK) begin
        ost_q <= OST;
        rd_q  <= RD;
        if (OST && !ost_q) ost_rises <= ost_rises + 1;
        if (RD && !rd_q) rd_rises <= rd_rises + 1;
        if (callee_stuck) begin
            ORD <= 1'b1;
        end else if (ORD && OST && !ost_q) begin
            ORD  <= 1'b0;
            cnt  <= callee_busy - 1;
            ORES <= callee_xor ? (OIN0 ^ OIN1) : callee_val;
        end else if (!ORD) begin
            if (cnt == 0) ORD <= 1'b1;
            else cnt <= cnt - 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Raise ST so the next edge (edge 0) samples the rise; returns after edge 0.
    task automatic start_op(input logic [BW-1:0] a, input logic [BW-1:0] b);
        IN0 = a;
        IN1 = b;
        ST  = 1'b1;
        tick();
        ST  = 1'b0;
    endtask

    task automatic wait_rd(output int n);
        n = 0;
        while (RD !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_callee_idle();
        int k = 0;
        while (ORD !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        ST  = 1'b1;
        repeat (3) tick();
        tests++;
        if (RD !== 1'b1 || OST !== 1'b0 || RES !== 16'h0000 || ERR !== 1'b0 ||
            OIN0 !== 16'h0000 || OIN1 !== 16'h0000) begin
            fails++;
            $display("FAIL reset_values: RD=%b OST=%b RES=%h ERR=%b OIN0=%h OIN1=%h, want 1 0 0000 0 0000 0000",
                     RD, OST, RES, ERR, OIN0, OIN1);
        end
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (OST !== 1'b0 || RD !== 1'b1) begin
                fails++;
                $display("FAIL st_held_over_reset cycle %0d: OST=%b RD=%b, want 0 1", i, OST, RD);
            end
        end
        ST = 1'b0;
        tick();
    endtask

    task automatic test_zero_op();
        int n;
        callee_xor  = 1'b0;
        callee_val  = 16'h0000;
        callee_busy = 2;
        start_op(16'h1234, 16'hABCD);
        tests++;
        if (OST !== 1'b1 || RD !== 1'b0 || OIN0 !== 16'h1234 || OIN1 !== 16'hABCD) begin
            fails++;
            $display("FAIL zero_op_edge0: OST=%b RD=%b OIN0=%h OIN1=%h, want 1 0 1234 abcd",
                     OST, RD, OIN0, OIN1);
        end
        tick();
        tick();
        tests++;
        if (OST !== 1'b0) begin
            fails++;
            $display("FAIL zero_op_edge2_ost: OST=%b, want 0", OST);
        end
        wait_rd(n);
        tests++;
        if (n + 2 !== 4 || RES !== 16'h0000 || ERR !== 1'b0) begin
            fails++;
            $display("FAIL zero_op_done: edge=%0d RES=%h ERR=%b, want 4 0000 0", n + 2, RES, ERR);
        end
        wait_callee_idle();
    endtask

    task automatic test_busy7();
        int n;
        callee_xor  = 1'b0;
        callee_val  = 16'h00FF;
        callee_busy = 7;
        start_op(16'h0001, 16'h0002);
        wait_rd(n);
        tests++;
        if (n !== 9 || RES !== 16'h00FF || ERR !== 1'b0) begin
            fails++;
            $display("FAIL busy7: edge=%0d RES=%h ERR=%b, want 9 00ff 0", n, RES, ERR);
        end
        wait_callee_idle();
    endtask

    task automatic test_timeout();
        int n;
        callee_stuck = 1'b1;
        start_op(16'h1111, 16'h2222);
        wait_rd(n);
        tests++;
        if (n !== TMO || ERR !== 1'b1 || RES !== 16'h0000 || OST !== 1'b0) begin
            fails++;
            $display("FAIL timeout: edge=%0d ERR=%b RES=%h OST=%b, want %0d 1 0000 0",
                     n, ERR, RES, OST, TMO);
        end
        callee_stuck = 1'b0;
        callee_xor   = 1'b1;
        callee_busy  = 2;
        start_op(16'h3000, 16'h0C00);
        tests++;
        if (ERR !== 1'b0 || OST !== 1'b1) begin
            fails++;
            $display("FAIL timeout_clear_err: ERR=%b OST=%b, want 0 1", ERR, OST);
        end
        wait_rd(n);
        tests++;
        if (n !== 4 || RES !== 16'h3C00 || ERR !== 1'b0) begin
            fails++;
            $display("FAIL after_timeout: edge=%0d RES=%h ERR=%b, want 4 3c00 0", n, RES, ERR);
        end
        wait_callee_idle();
    endtask

    task automatic test_ignored_start();
        int n;
        int r0, c0;
        callee_xor  = 1'b1;
        callee_busy = 2;
        start_op(16'h00F0, 16'h0F00);
        r0 = ost_rises;
        c0 = rd_rises;
        tick();
        ST = 1'b1;
        tick();
        ST = 1'b0;
        wait_rd(n);
        repeat (3) tick();
        tests++;
        if (n + 2 !== 4 || RES !== 16'h0FF0 || ost_rises - r0 !== 1 || rd_rises - c0 !== 1 || OST !== 1'b0) begin
            fails++;
            $display("FAIL ignored_start: edge=%0d RES=%h ost_pulses=%0d completions=%0d OST=%b, want 4 0ff0 1 1 0",
                     n + 2, RES, ost_rises - r0, rd_rises - c0, OST);
        end
        wait_callee_idle();
    endtask

    task automatic test_random();
        int n, busy, exp_edge;
        logic [BW-1:0] a, b, exp_res;
        logic exp_err;
        callee_xor = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a = BW'($urandom);
            b = BW'($urandom);
            busy = (i == 0) ? 14 : (i == 1) ? 15 : int'($urandom_range(1, 18));
            callee_busy = busy;
            // Completion at edge 2+busy unless that lies beyond the watchdog edge TMO.
            if (busy + 2 <= TMO) begin
                exp_edge = busy + 2;
                exp_res  = a ^ b;
                exp_err  = 1'b0;
            end else begin
                exp_edge = TMO;
                exp_res  = '0;
                exp_err  = 1'b1;
            end
            start_op(a, b);
            wait_rd(n);
            tests++;
            if (n !== exp_edge || RES !== exp_res || ERR !== exp_err || OIN0 !== a || OIN1 !== b) begin
                fails++;
                $display("FAIL random[%0d] busy=%0d: edge=%0d RES=%h ERR=%b OIN0=%h OIN1=%h, want %0d %h %b %h %h",
                         i, busy, n, RES, ERR, OIN0, OIN1, exp_edge, exp_res, exp_err, a, b);
            end
            wait_callee_idle();
        end
    endtask

    task automatic test_reset_in_wait();
        int n;
        callee_xor  = 1'b1;
        callee_busy = 2;
        start_op(16'h0F0F, 16'h00F0);
        wait_rd(n);
        tests++;
        if (n !== 4 || RES !== 16'h0FFF) begin
            fails++;
            $display("FAIL rst_pre_op: edge=%0d RES=%h, want 4 0fff", n, RES);
        end
        callee_busy = 5;
        start_op(16'h5555, 16'h1111);
        tick();
        tick();
        tests++;
        if (OST !== 1'b0 || RD !== 1'b0) begin
            fails++;
            $display("FAIL rst_in_wait_state: OST=%b RD=%b, want 0 0", OST, RD);
        end
        RST = 1'b1;
        tick();
        tests++;
        if (RD !== 1'b1 || OST !== 1'b0 || RES !== 16'h0000 || ERR !== 1'b0 || OIN0 !== 16'h0000) begin
            fails++;
            $display("FAIL rst_in_wait: RD=%b OST=%b RES=%h ERR=%b OIN0=%h, want 1 0 0000 0 0000",
                     RD, OST, RES, ERR, OIN0);
        end
        RST = 1'b0;
        wait_callee_idle();
        callee_busy = 2;
        start_op(16'h2222, 16'h4444);
        wait_rd(n);
        tests++;
        if (n !== 4 || RES !== 16'h6666 || ERR !== 1'b0) begin
            fails++;
            $display("FAIL rst_after_start: edge=%0d RES=%h ERR=%b, want 4 6666 0", n, RES, ERR);
        end
    endtask

    initial begin
        test_reset();
        test_zero_op();
        test_busy7();
        test_timeout();
        test_ignored_start();
        test_random();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

endmodule
